// File: rtl/car_detect_pkg.sv
// car_detect_pkg: shared state type and sensor-pair encodings for the car gate detector
package car_detect_pkg;
    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, FAULT} cd_state_t;
    localparam logic [1:0] AB_CLEAR = 2'b00;
    localparam logic [1:0] AB_OUTER = 2'b10;
    localparam logic [1:0] AB_BOTH  = 2'b11;
    localparam logic [1:0] AB_INNER = 2'b01;
endpackage

// File: rtl/sync2.sv
// sync2: one-bit two-flop synchronizer with synchronous active-high reset
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;
    // shift the async input through two flops, both cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end
    assign o_q = r_sync;
endmodule

// File: rtl/car_detect.sv
// car_detect: two-beam gate FSM emitting enter/exit pulses and a fault flag; CAR_DETECT_SYNC_EN adds input synchronizers
module car_detect
    import car_detect_pkg::*;
(
    input  logic clk,
    input  logic Reset,
    input  logic a,
    input  logic b,
    output logic enter,
    output logic exit,
    output logic fault
);
    logic      w_a;
    logic      w_b;
    logic [1:0] w_ab;
    cd_state_t r_state;
    cd_state_t w_next;
    logic      w_enter;
    logic      w_exit;
    logic      r_enter;
    logic      r_exit;
    logic      r_fault;

`ifdef CAR_DETECT_SYNC_EN
    sync2 u_sync_a (.clk(clk), .rst(Reset), .i_d(a), .o_q(w_a));
    sync2 u_sync_b (.clk(clk), .rst(Reset), .i_d(b), .o_q(w_b));
`else
    assign w_a = a;
    assign w_b = b;
`endif

    assign w_ab = {w_a, w_b};

    // next-state walk along the entry/exit beam sequences; pulses fire on completing the last step
    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        w_exit  = 1'b0;
        case (r_state)
            IDLE:  w_next = (w_ab == AB_OUTER) ? EN1 : (w_ab == AB_INNER) ? EX1 : (w_ab == AB_BOTH) ? FAULT : IDLE;
            EN1:   w_next = (w_ab == AB_BOTH) ? EN2 : (w_ab == AB_CLEAR) ? IDLE : (w_ab == AB_INNER) ? FAULT : EN1;
            EN2:   w_next = (w_ab == AB_INNER) ? EN3 : (w_ab == AB_OUTER) ? EN1 : (w_ab == AB_CLEAR) ? FAULT : EN2;
            EN3: begin
                w_next  = (w_ab == AB_BOTH) ? EN2 : (w_ab == AB_OUTER) ? FAULT : (w_ab == AB_CLEAR) ? IDLE : EN3;
                w_enter = (w_ab == AB_CLEAR);
            end
            EX1:   w_next = (w_ab == AB_BOTH) ? EX2 : (w_ab == AB_CLEAR) ? IDLE : (w_ab == AB_OUTER) ? FAULT : EX1;
            EX2:   w_next = (w_ab == AB_OUTER) ? EX3 : (w_ab == AB_INNER) ? EX1 : (w_ab == AB_CLEAR) ? FAULT : EX2;
            EX3: begin
                w_next = (w_ab == AB_BOTH) ? EX2 : (w_ab == AB_INNER) ? FAULT : (w_ab == AB_CLEAR) ? IDLE : EX3;
                w_exit = (w_ab == AB_CLEAR);
            end
            FAULT: w_next = (w_ab == AB_CLEAR) ? IDLE : FAULT;
            default: w_next = IDLE;
        endcase
    end

    // state and registered outputs; fault tracks the state it is entering
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_enter <= 1'b0;
            r_exit  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_enter <= w_enter;
            r_exit  <= w_exit;
            r_fault <= (w_next == FAULT);
        end
    end

    assign enter = r_enter;
    assign exit  = r_exit;
    assign fault = r_fault;
endmodule

// File: tb/tb_car_detect.sv
// tb_car_detect: randomized and directed checks of car_detect against a path-position reference model
module tb_car_detect;
    import car_detect_pkg::*;

`ifdef CAR_DETECT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic a;
    logic b;
    logic o_enter;
    logic o_exit;
    logic o_fault;

    int total = 0;
    int bad = 0;
    int n_enter = 0;
    int n_exit = 0;

    int         m_mode;
    int         m_pos;
    logic       e_enter;
    logic       e_exit;
    logic       e_fault;
    logic [1:0] pipe0;
    logic [1:0] pipe1;

    car_detect dut (
        .clk(clk), .Reset(rst), .a(a), .b(b),
        .enter(o_enter), .exit(o_exit), .fault(o_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // beam pattern at position p along a passage (0 = clear); exit passages swap the beams
    function automatic logic [1:0] pab(input bit ex, input int p);
        logic [1:0] v;
        v = (p == 1) ? 2'b10 : (p == 2) ? 2'b11 : (p == 3) ? 2'b01 : 2'b00;
        return ex ? {v[0], v[1]} : v;
    endfunction

    function automatic int pidx(input bit ex, input logic [1:0] ab);
        for (int p = 0; p < 4; p++) if (pab(ex, p) == ab) return p;
        return 0;
    endfunction

    // mode 0 idle, 1 entering, 2 exiting, 3 fault; a passage may move one position at a time
    task automatic model(input logic [1:0] ab);
        int idx;
        e_enter = 1'b0;
        e_exit  = 1'b0;
        if (m_mode == 3) begin
            if (ab == 2'b00) m_mode = 0;
        end else if (m_mode == 0) begin
            if (ab == 2'b10) begin m_mode = 1; m_pos = 1; end
            else if (ab == 2'b01) begin m_mode = 2; m_pos = 1; end
            else if (ab == 2'b11) m_mode = 3;
        end else begin
            idx = pidx(m_mode == 2, ab);
            if (m_pos == 3 && ab == 2'b00) begin
                e_enter = (m_mode == 1);
                e_exit  = (m_mode == 2);
                m_mode  = 0;
            end else if (idx == m_pos + 1 || idx == m_pos - 1) begin
                m_pos = idx;
                if (idx == 0) m_mode = 0;
            end else if (idx != m_pos) begin
                m_mode = 3;
            end
        end
        e_fault = (m_mode == 3);
    endtask

    task automatic step(input logic [1:0] ab, input logic r);
        logic [1:0] seen;
        {a, b} = ab;
        rst = r;
        @(posedge clk);
        if (r) begin
            m_mode = 0; m_pos = 0; e_enter = 0; e_exit = 0; e_fault = 0;
            pipe0 = 2'b00; pipe1 = 2'b00;
        end else begin
            seen = (LAT == 0) ? ab : pipe1;
            pipe1 = pipe0;
            pipe0 = ab;
            model(seen);
        end
        #1;
        check("enter", o_enter, e_enter);
        check("exit", o_exit, e_exit);
        check("fault", o_fault, e_fault);
        n_enter += int'(o_enter);
        n_exit  += int'(o_exit);
    endtask

    task automatic passage(input bit ex);
        step(pab(ex, 1), 0);
        step(pab(ex, 2), 0);
        step(pab(ex, 3), 0);
        step(2'b00, 0);
    endtask

    task automatic settle();
        repeat (LAT + 3) step(2'b00, 0);
    endtask

    task automatic counts(input string tag, input int en, input int ex);
        check({tag, "_enters"}, n_enter, en);
        check({tag, "_exits"}, n_exit, ex);
        n_enter = 0;
        n_exit = 0;
    endtask

    initial begin
        int wpos;
        bit wdir;
        int r;
        int k;
        m_mode = 0; m_pos = 0; e_enter = 0; e_exit = 0; e_fault = 0;
        pipe0 = 0; pipe1 = 0;
        {a, b} = 2'b00;
        rst = 1'b1;
        step(2'b00, 1);
        check("reset_state", dut.r_state, IDLE);
        settle();
        counts("reset", 0, 0);

        passage(0);
        repeat (LAT) step(2'b00, 0);
        check("entry_latency", o_enter, 1);
        step(2'b00, 0);
        check("entry_one_cycle", o_enter, 0);
        settle();
        counts("entry", 1, 0);

        passage(1);
        settle();
        counts("exit", 0, 1);

        repeat (26) passage(0);
        settle();
        counts("entry26", 26, 0);

        step(2'b10, 0); step(2'b11, 0); step(2'b10, 0); step(2'b00, 0);
        settle();
        check("reversal_fault", o_fault, 0);
        check("reversal_idle", dut.r_state, IDLE);
        counts("reversal", 0, 0);

        step(2'b11, 0);
        repeat (LAT) step(2'b11, 0);
        check("fault_set", o_fault, 1);
        step(2'b11, 0); step(2'b10, 0); step(2'b01, 0);
        repeat (LAT) step(2'b01, 0);
        check("fault_held", o_fault, 1);
        settle();
        check("fault_clear", o_fault, 0);
        counts("fault", 0, 0);

        step(2'b10, 0); step(2'b11, 0); step(2'b01, 0);
        repeat (LAT + 1) step(2'b01, 0);
        check("in_en3", dut.r_state, EN3);
        step(2'b01, 1);
        settle();
        check("abort_idle", dut.r_state, IDLE);
        counts("abort", 0, 0);

        wpos = 0;
        wdir = 0;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(pab(wdir, wpos), 1);
            end else if (r < 6) begin
                step(2'($urandom_range(0, 3)), 0);
            end else begin
                k = $urandom_range(0, 3);
                if (k == 1 || k == 3) begin
                    if (wpos == 3) wpos = 0;
                    else wpos++;
                end else if (k == 2 && wpos > 0) begin
                    wpos--;
                end
                if (wpos == 0) wdir = 1'($urandom_range(0, 1));
                step(pab(wdir, wpos), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
